seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one `seven_segment` BCD decoder among up to eight common-anode digits of the elevator floor/status display. It holds a double-buffered copy of the digit values, presents one BCD nibble at a time to the shared decoder, and drives active-low digit enables with a blanking gap between digits to prevent ghosting. Display updates are frame-synchronous, so a multi-digit value never tears mid-scan.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned; legal range 1..8.
- `REFRESH_DIV`, 1000: clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 8: cycles at the start of each slot with all digits off; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `digits_in`  in  4*NUM_DIGITS  BCD digits; nibble i drives digit i, and digit 0 is least significant.
- `load`  in  1  single-cycle strobe that captures `digits_in` into the pending buffer.
- `digit_en`  in  NUM_DIGITS  per-digit enable mask, sampled live.
- `bcd_out`  out  4  nibble routed to the shared decoder's `input_num`.
- `digit_sel_n`  out  NUM_DIGITS  active-low digit enables.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Registers:
  - `active` buffer, 4*NUM_DIGITS bits: the values being displayed.
  - `pending` buffer, 4*NUM_DIGITS bits, plus a `pend_valid` flag.
  - Slot counter `cnt`, $clog2(REFRESH_DIV) bits, counting 0..REFRESH_DIV-1 and wrapping.
  - Digit index `idx`, counting 0..NUM_DIGITS-1 and wrapping.
- Slot FSM has two states:
  - BLANK holds while `cnt` < BLANK_CYCLES.
  - SHOW holds while `cnt` >= BLANK_CYCLES.
  - BLANK→SHOW happens at `cnt` == BLANK_CYCLES-1.
  - SHOW→BLANK happens at `cnt` == REFRESH_DIV-1; on that edge `idx` increments, wrapping to 0.
- In BLANK, `digit_sel_n` is all ones and `bcd_out` holds `active[idx]`.
- In SHOW, `digit_sel_n[idx]` is 0 only if `digit_en[idx]`=1 and the digit is not suppressed (see Configuration). All other bits are 1.
- A disabled digit still consumes its slot, so brightness and frame period stay constant.
- `load`=1 writes `digits_in` into `pending` and sets `pend_valid`. A later load before the frame boundary overwrites `pending` (last write wins).
- Frame boundary is the edge ending the last cycle of slot NUM_DIGITS-1:
  - If `load` is high in that cycle, `digits_in` goes directly into `active` and `pend_valid` clears.
  - Else, if `pend_valid` is set, `pending` goes into `active` and `pend_valid` clears.
  - Otherwise `active` is unchanged.
- Nibbles 10..15 pass through unmodified; the decoder handles them.

## Timing
- Reset values:
  - `bcd_out` = 0, `digit_sel_n` = all ones, `frame_done` = 0.
  - `cnt` = 0, `idx` = 0, state = BLANK.
  - `active`, `pending` = 0; `pend_valid` = 0.
- Reset asserted mid-frame returns to these values immediately (asynchronous). Scanning restarts at digit 0, BLANK, on the first clock after `rst_n` rises.
- All outputs are registered. Slot k begins on the clock edge at which `cnt` becomes 0.
- `bcd_out` changes on the first BLANK cycle of a slot.
- `digit_sel_n` is low for exactly REFRESH_DIV-BLANK_CYCLES consecutive cycles per enabled slot.
- Frame period is exactly NUM_DIGITS*REFRESH_DIV cycles. `frame_done` is high for one cycle every frame.
- `load`-to-display latency is at most one frame plus BLANK_CYCLES. The new value is never shown partway through a frame.
- `digit_en` changes take effect on the next cycle's `digit_sel_n`, but never during BLANK.

## Configuration
- Macro `SEG_SCAN_LZ_SUPPRESS_EN` controls leading-zero suppression.
- Defined:
  - Scanning from digit NUM_DIGITS-1 downward, each `active` nibble equal to 0 is suppressed (anode held off in SHOW) until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - Suppression is computed from `active`, so it is stable for the whole frame.
- Undefined: no suppression logic is built; zeros display normally.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=16, BLANK_CYCLES=2.
- Reset, then free-run 64 cycles → `digit_sel_n` sequence 1110, 1101, 1011, 0111, each low 14 cycles after 2 all-ones cycles; `frame_done` pulses at cycle 63; `bcd_out`=0.
- `load` with `digits_in`=16'h4321 in the middle of frame 0 → frame 0 still shows 0s; frame 1 shows `bcd_out` 1,2,3,4 in slots 0..3.
- Two loads (16'h1111, then 16'h2222) in the same frame → next frame shows 2s only. A load coinciding with the `frame_done` cycle with 16'h5555 → the following frame shows 5s.
- `digit_en`=4'b1010 → slots 0 and 2 keep `digit_sel_n` all ones; frame period is still 64 cycles.
- With SEG_SCAN_LZ_SUPPRESS_EN defined, active=16'h0030 → digits 3 and 2 dark, digits 1 and 0 lit. active=16'h0000 → only digit 0 lit. Macro undefined → all four lit.
- Deassert `rst_n` during SHOW of slot 2 → outputs are at reset values in the same cycle, `active` is cleared, and scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a shared BCD decoder.
// Build option: SEG_SCAN_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic                    frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DW-1:0]       active_q, active_d;
   logic [DW-1:0]       pend_q, pend_d;
   logic                pv_q, pv_d;
   logic [3:0]          bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                fd_q, fd_d;
   logic [NUM_DIGITS-1:0] supp;
   logic                slot_end;
   logic                frame_end;

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   // Slot FSM: blanking gap at the start of each slot, then show.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_SHOW;
         S_SHOW:  if (slot_end) state_d = S_BLANK;
         default: state_d = S_BLANK;
      endcase
   end

   // Slot counter and digit index advance.
   always_comb begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Double buffer: loads land in pending, swap into active only at frame end.
   always_comb begin
      active_d = active_q;
      pend_d   = pend_q;
      pv_d     = pv_q;
      if (frame_end) begin
         if (load) begin
            active_d = digits_in;
            pv_d     = 1'b0;
         end else if (pv_q) begin
            active_d = pend_q;
            pv_d     = 1'b0;
         end
      end else if (load) begin
         pend_d = digits_in;
         pv_d   = 1'b1;
      end
   end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
   logic lead;

   // Dark every zero above the first nonzero digit; digit 0 always shows.
   always_comb begin
      supp = '0;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lead && (active_d[4*i +: 4] == 4'd0)) begin
            supp[i] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   // No suppression: every enabled digit lights.
   always_comb begin
      supp = '0;
   end
`endif

   // Next values of the registered outputs, aligned with the next slot state.
   always_comb begin
      bcd_d = 4'd0;
      sel_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            bcd_d = active_d[4*i +: 4];
            if ((state_d == S_SHOW) && digit_en[i] && !supp[i]) begin
               sel_d[i] = 1'b0;
            end
         end
      end
      fd_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
   end

   // Slot FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, buffers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         active_q <= '0;
         pend_q   <= '0;
         pv_q     <= 1'b0;
         bcd_q    <= 4'd0;
         sel_q    <= '1;
         fd_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         pv_q     <= pv_d;
         bcd_q    <= bcd_d;
         sel_q    <= sel_d;
         fd_q     <= fd_d;
      end
   end

   assign bcd_out     = bcd_q;
   assign digit_sel_n = sel_q;
   assign frame_done  = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scan/load/reset sequence with a cycle scoreboard.
// Build option: SEG_SCAN_LZ_SUPPRESS_EN selects the suppression expectations.
module tb_seg_scan_ctrl;

   localparam int ND  = 4;
   localparam int RD  = 16;
   localparam int BC  = 2;
   localparam int FRM = ND * RD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits_in;
   logic        load;
   logic [3:0]  digit_en;
   logic [3:0]  bcd_out;
   logic [3:0]  digit_sel_n;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] m_act;
   logic [15:0] m_pend;
   logic        m_pv;
   logic [8:0]  sb[$];

   seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .load       (load),
      .digit_en   (digit_en),
      .bcd_out    (bcd_out),
      .digit_sel_n(digit_sel_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] m_supp(input logic [15:0] a);
      logic [3:0] s;
      s = 4'b0000;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
      for (int i = 3; i >= 1; i--) begin
         if (a[4*i +: 4] != 4'd0) break;
         s[i] = 1'b1;
      end
`endif
      return s;
   endfunction

   // One clock: apply buffer rules for the ending cycle, predict the next.
   task automatic step();
      int n;
      int cnt;
      int idx;
      logic [3:0] s;
      logic [3:0] sel;
      logic [8:0] got;
      logic [8:0] expv;
      if ((cyc % FRM) == FRM - 1) begin
         if (load) begin
            m_act = digits_in;
            m_pv  = 1'b0;
         end else if (m_pv) begin
            m_act = m_pend;
            m_pv  = 1'b0;
         end
      end else if (load) begin
         m_pend = digits_in;
         m_pv   = 1'b1;
      end
      n   = cyc + 1;
      cnt = n % RD;
      idx = (n / RD) % ND;
      s   = m_supp(m_act);
      sel = 4'hF;
      if (cnt >= BC && digit_en[idx] && !s[idx]) sel[idx] = 1'b0;
      sb.push_back({sel, m_act[idx*4 +: 4], ((n % FRM) == FRM - 1)});
      @(posedge clk);
      #1;
      got  = {digit_sel_n, bcd_out, frame_done};
      expv = sb.pop_front();
      chk("scan", 32'(got), 32'(expv));
      cyc++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic pulse(input logic [15:0] d);
      load      = 1'b1;
      digits_in = d;
      step();
      load      = 1'b0;
   endtask

   task automatic model_reset();
      cyc    = 0;
      m_act  = '0;
      m_pend = '0;
      m_pv   = 1'b0;
      sb.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      digit_en  = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 32'(digit_sel_n), 32'h F);
      chk("rst_bcd", 32'(bcd_out), 32'h0);
      chk("rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      step();
      chk("blank_c1", 32'(digit_sel_n), 32'b1111);
      step();
      chk("slot0_on", 32'(digit_sel_n), 32'b1110);
      run_to(18);
      chk("slot1_on", 32'(digit_sel_n), 32'b1101);
      run_to(63);
      chk("fd_c63", 32'(frame_done), 32'h1);
      chk("slot3_on", 32'(digit_sel_n), 32'b0111);

      run_to(90);
      pulse(16'h4321);
      run_to(100);
      chk("f1_still0", 32'(bcd_out), 32'h0);
      run_to(130);
      chk("f2_d0", 32'(bcd_out), 32'h1);
      run_to(165);
      chk("f2_d2", 32'(bcd_out), 32'h3);

      run_to(200);
      pulse(16'h1111);
      run_to(230);
      pulse(16'h2222);
      run_to(260);
      chk("last_wins", 32'(bcd_out), 32'h2);
      run_to(319);
      chk("fd_c319", 32'(frame_done), 32'h1);
      pulse(16'h5555);
      chk("boundary_ld", 32'(bcd_out), 32'h5);

      run_to(383);
      digit_en = 4'b1010;
      run_to(390);
      chk("en_slot0", 32'(digit_sel_n), 32'b1111);
      run_to(406);
      chk("en_slot1", 32'(digit_sel_n), 32'b1101);
      run_to(422);
      chk("en_slot2", 32'(digit_sel_n), 32'b1111);
      run_to(447);
      chk("en_fd", 32'(frame_done), 32'h1);
      digit_en = 4'hF;

      run_to(460);
      pulse(16'h0030);
      run_to(533);
      chk("lz30_d1", 32'(digit_sel_n), 32'b1101);
      run_to(565);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
      chk("lz30_d3", 32'(digit_sel_n), 32'b1111);
`else
      chk("lz30_d3", 32'(digit_sel_n), 32'b0111);
`endif
      pulse(16'h0000);
      run_to(581);
      chk("lz00_d0", 32'(digit_sel_n), 32'b1110);
      run_to(597);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
      chk("lz00_d1", 32'(digit_sel_n), 32'b1111);
`else
      chk("lz00_d1", 32'(digit_sel_n), 32'b1101);
`endif

      run_to(600);
      pulse(16'h9876);
      run_to(680);
      chk("pre_rst_sel", 32'(digit_sel_n), 32'b1011);
      chk("pre_rst_bcd", 32'(bcd_out), 32'h8);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", 32'(digit_sel_n), 32'h F);
      chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
      chk("mid_rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_to(2);
      chk("restart_d0", 32'(digit_sel_n), 32'b1110);
      run_to(FRM + 4);
      chk("restart_clr", 32'(bcd_out), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
